// File: rtl/vdp_vram_arb.sv
// VDP VRAM arbiter: CPU mode0/mode1 port, read-ahead buffer, display priority.
// Ports: CPU ticks/din/dout, display req/addr/valid, VRAM bus, busy, overrun.
module vdp_vram_arb (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr0_tick,
  input  logic        rd0_tick,
  input  logic        wr1_tick,
  input  logic        rd1_tick,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        disp_req,
  input  logic [13:0] disp_addr,
  output logic        disp_valid,
  output logic        vram_en,
  output logic        vram_we,
  output logic [13:0] vram_addr,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_rdata,
  output logic        cpu_busy,
  output logic        overrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PEND,
    S_RDWAIT
  } state_t;

  state_t      state_q, state_d;
  logic        op_wr_q, op_wr_d;
  logic        phase_q, phase_d;
  logic [7:0]  lo_q, lo_d;
  logic [13:0] addr_q, addr_d;
  logic [7:0]  wbuf_q, wbuf_d;
  logic [7:0]  dout_q, dout_d;
  logic        dv_q, ov_q;

  logic busy;
  logic ld;
  logic issue;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_wr_q <= 1'b0;
      phase_q <= 1'b0;
      lo_q    <= '0;
      addr_q  <= '0;
      wbuf_q  <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      phase_q <= phase_d;
      lo_q    <= lo_d;
      addr_q  <= addr_d;
      wbuf_q  <= wbuf_d;
      dout_q  <= dout_d;
      dv_q    <= disp_req;
      ov_q    <= (wr0_tick | rd0_tick) & busy;
    end
  end

  always_comb begin
    state_d = state_q;
    op_wr_d = op_wr_q;
    phase_d = phase_q;
    lo_d    = lo_q;
    addr_d  = addr_q;
    wbuf_d  = wbuf_q;
    dout_d  = dout_q;

    busy = (state_q != S_IDLE);
    // second mode1 byte with din[7]=0 is an address load
    ld = wr1_tick & phase_q & ~din[7];
    // a same-cycle address load discards the pending op before it issues
    issue = (state_q == S_PEND) & ~disp_req & ~ld & ~reset;

    if (rd1_tick | wr0_tick | rd0_tick)
      phase_d = 1'b0;
    else if (wr1_tick)
      phase_d = ~phase_q;

    if (wr1_tick & ~phase_q)
      lo_d = din;

    unique case (state_q)
      S_IDLE: begin
        if (wr0_tick) begin
          wbuf_d  = din;
          op_wr_d = 1'b1;
          state_d = S_PEND;
        end else if (rd0_tick) begin
          op_wr_d = 1'b0;
          state_d = S_PEND;
        end
      end
      S_PEND: begin
        if (issue) begin
          if (op_wr_q) begin
            addr_d  = addr_q + 14'd1;
            state_d = S_IDLE;
          end else begin
            state_d = S_RDWAIT;
          end
        end
      end
      S_RDWAIT: begin
        dout_d  = vram_rdata;
        addr_d  = addr_q + 14'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // load overrides the capture increment but not the capture itself
    if (ld) begin
      addr_d = {din[5:0], lo_q};
      if (din[6]) begin
        state_d = S_IDLE;
      end else begin
        op_wr_d = 1'b0;
        state_d = S_PEND;
      end
    end
  end

  assign vram_en    = disp_req | issue;
  assign vram_we    = issue & op_wr_q;
  assign vram_addr  = disp_req ? disp_addr : addr_q;
  assign vram_wdata = wbuf_q;
  assign dout       = dout_q;
  assign disp_valid = dv_q;
  assign cpu_busy   = busy;
  assign overrun    = ov_q;

endmodule
